// File: rtl/spi_rx.sv
// SPI mode-0 slave receiver: synchronises the SPI pins into the system
// clock domain and delivers whole MSB-first words with frame/error flags.
module spi_rx #(
   parameter int c_word_w      = 8,
   parameter int c_sync_stages = 2,
   parameter int c_max_words   = 4096
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_dck,
   input  logic                               i_cs,
   input  logic                               i_mosi,
   output logic [c_word_w-1:0]                o_data,
   output logic                               o_valid,
   output logic                               o_start,
   output logic                               o_active,
   output logic [$clog2(c_max_words+1)-1:0]   o_words,
   output logic                               o_err
);

   localparam int c_cnt_w = $clog2(c_max_words + 1);
   localparam int c_bit_w = (c_word_w > 2) ? $clog2(c_word_w) : 1;

   typedef enum logic {st_idle, st_shift} state_t;

   state_t state, state_nx;

   logic [c_sync_stages-1:0] cs_sync;
   logic [c_sync_stages-1:0] dck_sync;
   logic [c_sync_stages-1:0] mosi_sync;
   logic [c_sync_stages-1:0] prime;
   logic                     dck_d;
   logic                     sync_cs;
   logic                     sync_mosi;
   logic                     dck_edge;
   logic                     armed;
   logic                     first;
   logic                     done;
   logic                     go;
   logic                     quit;
   logic                     shift_en;
   logic [c_word_w-1:0]      shreg;
   logic [c_bit_w-1:0]       bitcnt;

   assign sync_cs   = cs_sync[c_sync_stages-1];
   assign sync_mosi = mosi_sync[c_sync_stages-1];
   assign dck_edge  = dck_sync[c_sync_stages-1] & ~dck_d;

   // prime marks when the chains hold real samples, not reset presets
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cs_sync   <= '1;
         dck_sync  <= '0;
         mosi_sync <= '0;
         prime     <= '0;
         dck_d     <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[c_sync_stages-2:0], i_cs};
         dck_sync  <= {dck_sync[c_sync_stages-2:0], i_dck};
         mosi_sync <= {mosi_sync[c_sync_stages-2:0], i_mosi};
         prime     <= {prime[c_sync_stages-2:0], 1'b1};
         dck_d     <= dck_sync[c_sync_stages-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= st_idle;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         st_idle:  if (armed && !sync_cs) state_nx = st_shift;
         st_shift: if (sync_cs)           state_nx = st_idle;
      endcase
   end

   always_comb begin
      o_active = (state == st_shift);
      go       = (state == st_idle) && armed && !sync_cs;
      quit     = (state == st_shift) && sync_cs;
      shift_en = (state == st_shift) && !sync_cs && dck_edge;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         armed   <= 1'b0;
         first   <= 1'b0;
         done    <= 1'b0;
         shreg   <= '0;
         bitcnt  <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_start <= 1'b0;
         o_words <= '0;
         o_err   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         o_start <= 1'b0;
         o_err   <= 1'b0;
         done    <= 1'b0;
         if (state == st_idle && sync_cs && prime[c_sync_stages-1])
            armed <= 1'b1;
         if (shift_en) begin
            shreg <= {shreg[c_word_w-2:0], sync_mosi};
            if (bitcnt == c_bit_w'(c_word_w - 1)) begin
               bitcnt <= '0;
               done   <= 1'b1;
            end else begin
               bitcnt <= bitcnt + 1'b1;
            end
         end
         // a word finished just before cs release is still delivered
         if (done) begin
            o_data  <= shreg;
            o_valid <= 1'b1;
            o_start <= first;
            first   <= 1'b0;
            if (o_words != c_cnt_w'(c_max_words))
               o_words <= o_words + c_cnt_w'(1);
         end
         if (quit) begin
            bitcnt <= '0;
            o_err  <= (bitcnt != '0);
         end
         if (go) begin
            bitcnt  <= '0;
            o_words <= '0;
            first   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_rx.sv
// Randomised SPI frames against a word-level queue model of the receiver.
// Small saturation limit so frame word counts exercise the clamp.
module tb_spi_rx;

   localparam int W  = 8;
   localparam int S  = 2;
   localparam int M  = 4;
   localparam int CW = $clog2(M + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          dck;
   logic          cs;
   logic          mosi;
   logic [W-1:0]  o_data;
   logic          o_valid;
   logic          o_start;
   logic          o_active;
   logic [CW-1:0] o_words;
   logic          o_err;

   spi_rx #(.c_word_w(W), .c_sync_stages(S), .c_max_words(M)) dut (
      .i_clk(clk), .i_rst(rst), .i_dck(dck), .i_cs(cs), .i_mosi(mosi),
      .o_data(o_data), .o_valid(o_valid), .o_start(o_start),
      .o_active(o_active), .o_words(o_words), .o_err(o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      bit         st;
      int         w;
      int         t;
   } exp_t;

   exp_t q[$];
   exp_t e_cur;
   int   cyc = 0;
   int   pass_n = 0;
   int   tot_n = 0;
   int   err_exp = 0;
   int   err_seen = 0;
   int   val_seen = 0;
   int   hp = 2;
   int   fw = 0;
   int   snap;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string n, longint act, longint req);
      tot_n++;
      if (act == req) pass_n++;
      else $display("FAIL %s: got %0d, want %0d", n, act, req);
   endfunction

   // Word events are checked against the queue whenever the DUT raises them
   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs",
             {o_valid, o_start, o_err, o_active, o_data, o_words}, 0);
      end else begin
         if (o_err) err_seen++;
         if (o_start && !o_valid) chk("start_without_valid", 1, 0);
         if (o_valid) begin
            val_seen++;
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e_cur = q.pop_front();
               chk("data", o_data, e_cur.d);
               chk("start", o_start, e_cur.st);
               chk("words", o_words, e_cur.w);
               chk("latency", cyc - e_cur.t, S + 2);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      cs = 1'b0;
      fw = 0;
      tick(hp + 3);
   endtask

   task automatic cs_high();
      tick(hp);
      cs = 1'b1;
      tick(S + 6);
   endtask

   task automatic send_word(logic [7:0] d);
      for (int i = 7; i >= 0; i--) begin
         mosi = d[i];
         tick(hp);
         dck = 1'b1;
         if (i == 0) begin
            q.push_back('{d: d, st: (fw == 0),
                          w: (fw + 1 > M) ? M : fw + 1, t: cyc});
            fw++;
         end
         tick(hp);
         dck = 1'b0;
      end
   endtask

   task automatic send_bits(int n, logic [7:0] d);
      for (int i = 0; i < n; i++) begin
         mosi = d[7-i];
         tick(hp);
         dck = 1'b1;
         tick(hp);
         dck = 1'b0;
      end
   endtask

   task automatic pulse_rst();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic end_check(int words);
      chk("queue_drained", q.size(), 0);
      chk("err_count", err_seen, err_exp);
      chk("idle_words", o_words, words);
      chk("idle_active", o_active, 0);
   endtask

   initial begin
      rst  = 1'b1;
      cs   = 1'b1;
      dck  = 1'b0;
      mosi = 1'b0;
      tick(3);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(S + 4);
      chk("post_reset_words", o_words, 0);
      chk("post_reset_data", o_data, 0);

      // single word at f_clk/8
      hp = 4;
      cs_low();
      chk("active_in_frame", o_active, 1);
      send_word(8'hA5);
      cs_high();
      end_check(1);
      chk("lit_a5_data", o_data, 8'hA5);
      chk("lit_a5_words", o_words, 1);

      // three words, one frame
      hp = 2;
      snap = val_seen;
      cs_low();
      send_word(8'h01);
      send_word(8'h80);
      send_word(8'hFF);
      cs_high();
      end_check(3);
      chk("lit_three_valids", val_seen - snap, 3);
      chk("lit_ff_data", o_data, 8'hFF);

      // aborted word then a clean frame
      cs_low();
      send_bits(5, 8'hB7);
      err_exp++;
      cs_high();
      end_check(0);
      chk("lit_err_once", err_seen, 1);
      cs_low();
      send_word(8'h3C);
      cs_high();
      end_check(1);
      chk("lit_3c_data", o_data, 8'h3C);

      // reset in mid-word while cs stays low
      hp = 3;
      snap = val_seen;
      cs_low();
      send_bits(4, 8'hF0);
      pulse_rst();
      send_bits(4, 8'h0F);
      chk("lit_unarmed_after_rst", o_active, 0);
      send_bits(8, 8'h99);
      chk("lit_no_valid_after_rst", val_seen - snap, 0);
      cs_high();
      end_check(0);
      cs_low();
      send_word(8'h5A);
      cs_high();
      end_check(1);
      chk("lit_5a_data", o_data, 8'h5A);

      // saturation: six words with a limit of four
      hp = 2;
      snap = val_seen;
      cs_low();
      for (int i = 0; i < 6; i++) send_word(8'(8'h10 + i));
      cs_high();
      end_check(M);
      chk("lit_six_valids", val_seen - snap, 6);
      chk("lit_saturated", o_words, 4);

      for (int f = 0; f < 30; f++) begin
         int nw;
         int part;
         hp   = $urandom_range(2, 4);
         nw   = $urandom_range(0, 6);
         part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         cs_low();
         for (int i = 0; i < nw; i++) send_word(8'($urandom));
         if (part != 0) begin
            send_bits(part, 8'($urandom));
            err_exp++;
         end
         cs_high();
         end_check((nw > M) ? M : nw);
      end

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end

endmodule
